// File: rtl/lfsr_seq_ctrl.sv
// Command sequencer for the 4-bit mode-selectable LFSR datapath: owns mode, seed,
// load and step controls and executes SET_MODE / LOAD / RUN / MEASURE one at a time.
module lfsr_seq_ctrl #(
  parameter int LFSR_W = 4,
  parameter int MOD_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_arg,
  input  logic              abort,
  input  logic [LFSR_W-1:0] lfsr_q,
  output logic [MOD_W-1:0]  lfsr_mod,
  output logic [LFSR_W-1:0] lfsr_seed,
  output logic              lfsr_load,
  output logic              lfsr_step,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  period
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_MEAS,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_SET_MODE = 2'b00;
  localparam logic [1:0] OP_LOAD     = 2'b01;
  localparam logic [1:0] OP_RUN      = 2'b10;
  localparam logic [1:0] OP_MEASURE  = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_LOCKUP  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORTED = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LFSR_W-1:0]   ref_q;
  logic [MOD_W-1:0]    mod_q;
  logic [LFSR_W-1:0]   seed_q;
  logic [1:0]          status_q;
  logic [CNT_W-1:0]    period_q;

  logic meas_hit;
  logic meas_max;

  // Strobes are decoded from current state so an async reset drops them at once.
  always_comb begin
    meas_hit  = (cnt_q != '0) && (lfsr_q == ref_q);
    meas_max  = (cnt_q == CNT_MAX);
    lfsr_step = 1'b0;
    case (state_q)
      S_RUN:   lfsr_step = !abort;
      S_MEAS:  lfsr_step = !abort && !meas_hit && !meas_max;
      default: lfsr_step = 1'b0;
    endcase
  end

  assign lfsr_load = (state_q == S_LOAD);
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign lfsr_mod  = mod_q;
  assign lfsr_seed = seed_q;
  assign status    = status_q;
  assign period    = period_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ref_q    <= '0;
      mod_q    <= '0;
      seed_q   <= LFSR_W'(1);
      status_q <= ST_OK;
      period_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_SET_MODE: begin
                mod_q    <= cmd_arg[MOD_W-1:0];
                status_q <= ST_OK;
                state_q  <= S_DONE;
              end
              OP_LOAD: begin
                seed_q  <= cmd_arg[LFSR_W-1:0];
                state_q <= S_LOAD;
              end
              OP_RUN: begin
                cnt_q <= cmd_arg;
                if (cmd_arg == '0) begin
                  status_q <= ST_OK;
                  state_q  <= S_DONE;
                end else begin
                  state_q <= S_RUN;
                end
              end
              OP_MEASURE: begin
                ref_q   <= lfsr_q;
                cnt_q   <= '0;
                state_q <= S_MEAS;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
        S_LOAD: begin
          status_q <= (seed_q == '0) ? ST_LOCKUP : ST_OK;
          state_q  <= S_DONE;
        end
        // cnt_q holds the steps still to issue, including the current cycle.
        S_RUN: begin
          if (abort) begin
            status_q <= ST_ABORTED;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              status_q <= ST_OK;
              state_q  <= S_DONE;
            end
          end
        end
        // cnt_q holds the steps already issued since the reference was captured.
        S_MEAS: begin
          if (abort) begin
            status_q <= ST_ABORTED;
            period_q <= '0;
            state_q  <= S_DONE;
          end else if (meas_hit) begin
            status_q <= ST_OK;
            period_q <= cnt_q;
            state_q  <= S_DONE;
          end else if (meas_max) begin
            status_q <= ST_TIMEOUT;
            period_q <= '0;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: an LFSR datapath stand-in plus a per-command timeline model
// checked every cycle, and directed commands with literal latency/result expectations.
module tb_lfsr_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       abort;
  logic [3:0] lfsr_q;
  logic [2:0] lfsr_mod;
  logic [3:0] lfsr_seed;
  logic       lfsr_load;
  logic       lfsr_step;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [7:0] period;

  lfsr_seq_ctrl #(.LFSR_W(4), .MOD_W(3), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .abort     (abort),
    .lfsr_q    (lfsr_q),
    .lfsr_mod  (lfsr_mod),
    .lfsr_seed (lfsr_seed),
    .lfsr_load (lfsr_load),
    .lfsr_step (lfsr_step),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .period    (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acceptCyc = 0;
  int stepTotal = 0;
  int loadTotal = 0;
  int stepBase = 0;
  int loadBase = 0;
  int dpMode = 0;
  logic [3:0] lfsrReg = 4'h1;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: 0 = maximal x^4+x^3+1 LFSR, 1 = stuck, 2 = stub that jumps to 6.
  function automatic logic [3:0] nextLfsr(input logic [3:0] v, input int mode);
    if (mode == 0) return {v[2:0], v[3] ^ v[0]};
    if (mode == 1) return v;
    return 4'h6;
  endfunction

  always @(posedge clk) begin
    if (lfsr_load) lfsrReg <= lfsr_seed;
    else if (lfsr_step) lfsrReg <= nextLfsr(lfsrReg, dpMode);
  end
  assign lfsr_q = lfsrReg;

  always @(negedge clk) begin
    if (lfsr_step === 1'b1) stepTotal <= stepTotal + 1;
    if (lfsr_load === 1'b1) loadTotal <= loadTotal + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One record per expected busy cycle of a command, built when the command is accepted.
  typedef struct {
    bit         step;
    bit         load;
    bit         done;
    bit         abortable;
    bit         isMeas;
    bit         setPer;
    logic [1:0] st;
    logic [7:0] per;
  } rec_t;

  function automatic rec_t mkRec(bit step, bit load, bit dn, bit abortable, bit isMeas,
                                 bit setPer, logic [1:0] st, logic [7:0] per);
    rec_t r;
    r.step = step; r.load = load; r.done = dn; r.abortable = abortable;
    r.isMeas = isMeas; r.setPer = setPer; r.st = st; r.per = per;
    return r;
  endfunction

  function automatic int predictPeriod(input logic [3:0] start, input int mode);
    logic [3:0] v = start;
    for (int k = 1; k <= 255; k++) begin
      v = nextLfsr(v, mode);
      if (v == start) return k;
    end
    return 0;
  endfunction

  rec_t       tl[$];
  logic [2:0] mMod = 3'd0;
  logic [3:0] mSeed = 4'h1;
  logic [1:0] mStatus = 2'b00;
  logic [7:0] mPeriod = 8'd0;

  always @(negedge clk) begin : compare
    rec_t cur;
    bit   idle;
    int   p;
    if (!rst_n) begin
      tl.delete();
      mMod = 3'd0; mSeed = 4'h1; mStatus = 2'b00; mPeriod = 8'd0;
      idle = 1'b1;
    end else begin
      idle = (tl.size() == 0);
    end
    cur = idle ? mkRec(0, 0, 0, 0, 0, 0, 2'b00, 8'd0) : tl.pop_front();
    if (!idle && cur.abortable && abort) begin
      cur.step = 1'b0;
      tl.delete();
      tl.push_back(mkRec(0, 0, 1, 0, cur.isMeas, cur.isMeas, 2'b11, 8'd0));
    end
    if (cur.done) begin
      mStatus = cur.st;
      if (cur.setPer) mPeriod = cur.per;
    end
    checkOutput("cmd_ready", cmd_ready, idle);
    checkOutput("busy", busy, !idle);
    checkOutput("lfsr_step", lfsr_step, cur.step);
    checkOutput("lfsr_load", lfsr_load, cur.load);
    checkOutput("done", done, cur.done);
    checkOutput("lfsr_mod", lfsr_mod, mMod);
    checkOutput("lfsr_seed", lfsr_seed, mSeed);
    checkOutput("status", status, mStatus);
    checkOutput("period", period, mPeriod);
    if (rst_n && idle && cmd_valid) begin
      case (cmd_op)
        2'b00: begin
          mMod = cmd_arg[2:0];
          tl.push_back(mkRec(0, 0, 1, 0, 0, 0, 2'b00, 8'd0));
        end
        2'b01: begin
          mSeed = cmd_arg[3:0];
          tl.push_back(mkRec(0, 1, 0, 0, 0, 0, 2'b00, 8'd0));
          tl.push_back(mkRec(0, 0, 1, 0, 0, 0, (cmd_arg[3:0] == 4'h0) ? 2'b01 : 2'b00, 8'd0));
        end
        2'b10: begin
          for (int i = 0; i < int'(cmd_arg); i++)
            tl.push_back(mkRec(1, 0, 0, 1, 0, 0, 2'b00, 8'd0));
          tl.push_back(mkRec(0, 0, 1, 0, 0, 0, 2'b00, 8'd0));
        end
        default: begin
          p = predictPeriod(lfsrReg, dpMode);
          for (int i = 0; i < ((p == 0) ? 255 : p); i++)
            tl.push_back(mkRec(1, 0, 0, 1, 1, 0, 2'b00, 8'd0));
          tl.push_back(mkRec(0, 0, 0, 1, 1, 0, 2'b00, 8'd0));
          tl.push_back(mkRec(0, 0, 1, 0, 1, 1, (p == 0) ? 2'b10 : 2'b00, 8'(p)));
        end
      endcase
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] arg);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    acceptCyc = cyc;
    stepBase  = stepTotal;
    loadBase  = loadTotal;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input string name, output int latency);
    bit seen = 1'b0;
    latency = -1;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        latency = cyc - acceptCyc;
      end
    end
    checkOutput({name, "_done_seen"}, seen, 1'b1);
  endtask

  int lat;

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00; abort = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset_ready", cmd_ready, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_mod", lfsr_mod, 3'd0);
    checkOutput("reset_seed", lfsr_seed, 4'h1);
    checkOutput("reset_status", status, 2'b00);
    checkOutput("reset_period", period, 8'd0);

    $display("[TB] SET_MODE 0x05");
    applyStimulus(2'b00, 8'h05);
    waitDone("setmode", lat);
    checkOutput("setmode_latency", lat, 1);
    checkOutput("setmode_mod", lfsr_mod, 3'd5);
    checkOutput("setmode_ready_low", cmd_ready, 1'b0);
    @(posedge clk);
    #1 checkOutput("setmode_ready_again", cmd_ready, 1'b1);

    $display("[TB] LOAD 0x00");
    applyStimulus(2'b01, 8'h00);
    waitDone("load0", lat);
    checkOutput("load0_latency", lat, 2);
    checkOutput("load0_status", status, 2'b01);
    checkOutput("load0_seed", lfsr_seed, 4'h0);
    checkOutput("load0_loads", loadTotal - loadBase, 1);

    $display("[TB] LOAD 0x09 with abort held (ignored)");
    applyStimulus(2'b01, 8'h09);
    abort = 1'b1;
    waitDone("load9", lat);
    #1 abort = 1'b0;
    checkOutput("load9_latency", lat, 2);
    checkOutput("load9_status", status, 2'b00);

    $display("[TB] RUN 10");
    applyStimulus(2'b10, 8'd10);
    waitDone("run10", lat);
    checkOutput("run10_latency", lat, 11);
    checkOutput("run10_steps", stepTotal - stepBase, 10);

    $display("[TB] RUN 0");
    applyStimulus(2'b10, 8'd0);
    waitDone("run0", lat);
    checkOutput("run0_latency", lat, 1);
    checkOutput("run0_steps", stepTotal - stepBase, 0);

    $display("[TB] MEASURE maximal LFSR seeded 1");
    applyStimulus(2'b01, 8'h01);
    waitDone("load1", lat);
    #1 dpMode = 0;
    applyStimulus(2'b11, 8'h00);
    waitDone("meas15", lat);
    checkOutput("meas15_latency", lat, 17);
    checkOutput("meas15_steps", stepTotal - stepBase, 15);
    checkOutput("meas15_period", period, 8'd15);
    checkOutput("meas15_status", status, 2'b00);

    $display("[TB] MEASURE stuck LFSR");
    #1 dpMode = 1;
    applyStimulus(2'b11, 8'h00);
    waitDone("meas1", lat);
    checkOutput("meas1_latency", lat, 3);
    checkOutput("meas1_period", period, 8'd1);

    $display("[TB] MEASURE stub 5 then 6 (timeout)");
    #1 dpMode = 0;
    applyStimulus(2'b01, 8'h05);
    waitDone("load5", lat);
    #1 dpMode = 2;
    applyStimulus(2'b11, 8'h00);
    waitDone("meastmo", lat);
    checkOutput("meastmo_latency", lat, 257);
    checkOutput("meastmo_steps", stepTotal - stepBase, 255);
    checkOutput("meastmo_period", period, 8'd0);
    checkOutput("meastmo_status", status, 2'b10);

    $display("[TB] SET_MODE 0xFA");
    #1 dpMode = 0;
    applyStimulus(2'b00, 8'hFA);
    waitDone("setmodefa", lat);
    checkOutput("setmodefa_mod", lfsr_mod, 3'd2);
    checkOutput("setmodefa_period_held", period, 8'd0);

    $display("[TB] RUN 50 aborted at step 7");
    applyStimulus(2'b10, 8'd50);
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    waitDone("runabort", lat);
    checkOutput("runabort_latency", lat, 8);
    checkOutput("runabort_steps", stepTotal - stepBase, 6);
    checkOutput("runabort_status", status, 2'b11);

    $display("[TB] RUN 50 with reset mid-command");
    applyStimulus(2'b10, 8'd50);
    repeat (3) @(posedge clk);
    #1 checkOutput("rst_step_before", lfsr_step, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_step_drop", lfsr_step, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ready", cmd_ready, 1'b1);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_load", lfsr_load, 1'b0);
    checkOutput("rst_mod", lfsr_mod, 3'd0);
    checkOutput("rst_seed", lfsr_seed, 4'h1);
    checkOutput("rst_status", status, 2'b00);
    checkOutput("rst_period", period, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Command-driven sequencer for the 4-bit mode-selectable LFSR datapath in the TT user design. It owns the LFSR's mode, seed, load and step controls. It accepts one command at a time over a valid/ready handshake: set mode, load seed, run N steps, or measure period. It reports completion, status and measured period to the top-level I/O mux.

## Interface
Parameters:
- LFSR_W, 4: LFSR state / seed width.
- MOD_W, 3: tap-mode select width.
- CNT_W, 8: command argument and step-counter width; must be ≥ LFSR_W and ≥ MOD_W.

Ports:
- clk  in  1  single design clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept; high only in IDLE.
- cmd_op  in  2  00 SET_MODE, 01 LOAD, 10 RUN, 11 MEASURE.
- cmd_arg  in  CNT_W  operand: mode in [MOD_W-1:0], seed in [LFSR_W-1:0], or step count.
- abort  in  1  synchronous stop request for RUN/MEASURE.
- lfsr_q  in  LFSR_W  current LFSR state; updates on the edge ending any cycle with lfsr_step or lfsr_load high.
- lfsr_mod  out  MOD_W  registered tap mode.
- lfsr_seed  out  LFSR_W  registered seed value.
- lfsr_load  out  1  one-cycle load strobe.
- lfsr_step  out  1  advance strobe, one LFSR step per high cycle.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- status  out  2  registered result: 00 ok, 01 zero-seed lockup, 10 timeout, 11 aborted.
- period  out  CNT_W  registered MEASURE result; 0 on timeout or abort.

## Operation
- States: IDLE, LOAD, RUN, MEAS, DONE. Reset enters IDLE.
- Accept: a command is accepted on any edge with cmd_valid && cmd_ready. cmd_op and cmd_arg are sampled only at that edge.
- SET_MODE: lfsr_mod takes cmd_arg[MOD_W-1:0] at the accept edge. Next state is DONE, with status 00.
- LOAD: lfsr_seed takes cmd_arg[LFSR_W-1:0] at the accept edge. In the LOAD state, lfsr_load = 1 for exactly one cycle, then DONE. status = 01 if the seed is all-zero, else 00.
- RUN: the step counter loads cmd_arg.
  - If the argument is 0, go straight to DONE with status 00 and no steps.
  - Otherwise, in RUN, lfsr_step = 1 for exactly cmd_arg consecutive cycles, then DONE with status 00.
- MEASURE:
  - At the accept edge, the reference register takes lfsr_q and the counter clears.
  - In MEAS, cnt counts steps already issued.
  - If cnt ≠ 0 and lfsr_q == ref, then lfsr_step = 0, period ← cnt, status ← 00, and the next state is DONE.
  - Else if cnt == 2^CNT_W−1, then lfsr_step = 0, period ← 0, status ← 10, and the next state is DONE.
  - Else lfsr_step = 1 and cnt increments.
- lfsr_step and lfsr_load are decoded from state and counter. They are never both high. Neither is high outside LOAD/RUN/MEAS.
- abort:
  - In RUN or MEAS, abort forces lfsr_step = 0 that same cycle and next state DONE.
  - Result is status 11, and period ← 0 if in MEAS.
  - Ignored in IDLE, LOAD and DONE.
- DONE: done = 1 for one cycle and cmd_ready = 0, then IDLE.
- status and period change only on entry to DONE and hold until the next DONE. SET_MODE, LOAD and RUN leave period unchanged.
- lfsr_mod and lfsr_seed hold between commands.

## Timing
- Reset values: state IDLE, so cmd_ready = 1 and busy = 0. Also lfsr_mod = 0, lfsr_seed = 1, lfsr_load = 0, lfsr_step = 0, done = 0, status = 00, period = 0, counter = 0, ref = 0.
- Reset asserted mid-command returns everything to the reset values immediately. A pending step or load strobe drops asynchronously.
- Latency from accept edge T:
  - SET_MODE: done in cycle T+1; cmd_ready again at T+2.
  - LOAD: lfsr_load in cycle T+1; done at T+2.
  - RUN n (n > 0): lfsr_step in cycles T+1 … T+n; done at T+n+1.
  - RUN 0: done at T+1.
  - MEASURE with period p: lfsr_step in T+1 … T+p; compare hit in T+p+1; done at T+p+2.
  - MEASURE timeout: 255 steps; done at T+257.
- Back-to-back: cmd_valid held high is accepted again on the first IDLE edge. There is no skid; commands are never queued.
- abort in the same cycle as a compare hit: abort wins (status 11).

## Test plan
- Reset, then SET_MODE arg 8'h05 → lfsr_mod = 3'd5 at T+1, done pulse at T+1, cmd_ready low at T+1 and high at T+2.
- LOAD arg 8'h00 → lfsr_load high only at T+1, lfsr_seed = 0, done at T+2, status = 01. LOAD arg 8'h09 → status = 00.
- RUN arg 8'd10 → exactly 10 consecutive lfsr_step cycles, done at T+11. RUN arg 0 → zero steps, done at T+1.
- MEASURE with a bench LFSR model of period 15 seeded 4'h1 → 15 steps, period = 15, status = 00, done at T+17. A stuck model (lfsr_q constant) → period = 1.
- MEASURE with a stub driving lfsr_q = 4'h5 at accept and 4'h6 thereafter → 255 steps, period = 0, status = 10.
- RUN arg 8'd50 with abort pulsed at step 7 → no step that cycle, done next cycle, status = 11. Then rst_n low mid-RUN → lfsr_step drops immediately and all outputs return to reset values.
